// File: rtl/if_pkg.sv
// Shared widths, field offsets and entry packing for the fetch stage.
package if_pkg;

   localparam int          IF_ID_BUS_W  = 65;
   localparam int          BR_BUS_W     = 33;
   localparam logic [31:0] DEF_RESET_PC = 32'h1c00_0000;

   // {adef, pc[31:0], inst[31:0]}
   localparam int ADEF_BIT = 64;
   localparam int PC_LSB   = 32;
   localparam int INST_LSB = 0;

   // {br_taken, br_target[31:0]}
   localparam int BR_TAKEN_BIT = 32;

   function automatic logic [IF_ID_BUS_W-1:0] pack_entry(input logic        adef,
                                                         input logic [31:0] pc,
                                                         input logic [31:0] inst);
      return {adef, pc, inst};
   endfunction

endpackage

// File: rtl/if_fetch_buffered_if.sv
// Fetch-stage signal bundle: branch redirect, decode handshake, SRAM port.
interface if_fetch_buffered_if;
   import if_pkg::*;

   logic [BR_BUS_W-1:0]    br_bus;
   logic                   id_ready;
   logic                   if_valid;
   logic [IF_ID_BUS_W-1:0] if_to_id_bus;
   logic                   inst_sram_en;
   logic [3:0]             inst_sram_we;
   logic [31:0]            inst_sram_addr;
   logic [31:0]            inst_sram_wdata;
   logic [31:0]            inst_sram_rdata;

   // The fetch stage side.
   modport master (
      input  br_bus, id_ready, inst_sram_rdata,
      output if_valid, if_to_id_bus, inst_sram_en, inst_sram_we,
             inst_sram_addr, inst_sram_wdata
   );

   // The surrounding pipeline / SRAM side.
   modport slave (
      output br_bus, id_ready, inst_sram_rdata,
      input  if_valid, if_to_id_bus, inst_sram_en, inst_sram_we,
             inst_sram_addr, inst_sram_wdata
   );

endinterface

// File: rtl/if_inst_fifo.sv
// Small synchronous FIFO holding fetched entries; flush beats push and pop.
module if_inst_fifo #(
   parameter  int W     = 65,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_flush,
   input  logic [W-1:0]  i_data,
   output logic [CW-1:0] o_count,
   output logic [W-1:0]  o_head
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   // Entry storage; a flushed push is simply not written.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch_buffered.sv
// Instruction fetch: free-running PC, 1-cycle SRAM, credit-managed entry buffer.
module if_fetch_buffered
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int          DEPTH    = 4
) (
   input logic                 clk,
   input logic                 reset,
   if_fetch_buffered_if.master bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic                   w_br_taken;
   logic [31:0]            w_br_target;
   logic [CW-1:0]          w_count;
   logic [CW-1:0]          w_occ;
   logic [IF_ID_BUS_W-1:0] w_head;
   logic [IF_ID_BUS_W-1:0] w_push_data;
   logic                   w_nonempty;
   logic                   w_valid;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_credit;
   logic                   w_issue;
   logic                   w_aligned;
   logic [31:0]            w_req_pc;

   logic [31:0] r_fetch_pc;
   logic [31:0] r_inflight_pc;
   logic        r_inflight;
   logic        r_inflight_adef;  // misaligned issue: entry is synthesised, not read
   logic        r_stall;          // parked on a misaligned PC until redirected

   assign w_br_taken  = bus.br_bus[BR_TAKEN_BIT];
   assign w_br_target = bus.br_bus[31:0];

   assign w_nonempty = (w_count != '0);
   assign w_valid    = !reset && !w_br_taken && w_nonempty;
   assign w_pop      = w_valid && bus.id_ready;

   // A redirect discards whatever response lands in the same cycle.
   assign w_push      = r_inflight && !w_br_taken;
   assign w_push_data = pack_entry(r_inflight_adef, r_inflight_pc,
                                   r_inflight_adef ? 32'h0 : bus.inst_sram_rdata);

   // Occupancy once this cycle's response and pop settle; a new issue needs one free slot.
   assign w_occ    = w_count + CW'(r_inflight) - CW'(w_pop);
   assign w_credit = (w_occ < CW'(DEPTH));

   assign w_req_pc  = w_br_taken ? w_br_target : r_fetch_pc;
   assign w_aligned = (w_req_pc[1:0] == 2'b00);
   assign w_issue   = !reset && (w_br_taken || (!r_stall && w_credit));

   assign bus.inst_sram_en    = w_issue && w_aligned;
   assign bus.inst_sram_addr  = w_req_pc;
   assign bus.inst_sram_we    = 4'h0;
   assign bus.inst_sram_wdata = 32'h0;

   assign bus.if_valid     = w_valid;
   assign bus.if_to_id_bus = (!reset && w_nonempty) ? w_head : '0;

   // Fetch PC advance and tracking of the one outstanding request.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc      <= RESET_PC;
         r_inflight      <= 1'b0;
         r_inflight_pc   <= 32'h0;
         r_inflight_adef <= 1'b0;
         r_stall         <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_pc   <= w_req_pc;
            r_inflight_adef <= !w_aligned;
            r_stall         <= !w_aligned;
            r_fetch_pc      <= w_aligned ? (w_req_pc + 32'd4) : w_req_pc;
         end
      end
   end

   if_inst_fifo #(
      .W     (IF_ID_BUS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_br_taken),
      .i_data  (w_push_data),
      .o_count (w_count),
      .o_head  (w_head)
   );

endmodule

// File: tb/tb_if_fetch_buffered.sv
// Bench for if_fetch_buffered: constant vector table, corner sequences, random vs queue model.
module tb_if_fetch_buffered;
   import if_pkg::*;

   localparam logic [31:0] RST_PC = 32'h1c00_0000;
   localparam int          DEPTH  = 4;

   logic clk;
   logic reset;
   if_fetch_buffered_if bus ();

   if_fetch_buffered #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: queue of visible entries plus the one pending fetch.
   logic [64:0] mbuf[$];
   bit          pend_v;
   bit          pend_adef;
   logic [31:0] pend_pc;
   logic [31:0] m_pc;
   bit          m_stall;

   logic [31:0] sram_q;
   bit          sram_qv;

   typedef struct {
      bit          rst;
      bit          rdy;
      bit          ev;
      logic [31:0] epc;
      bit          een;
      logic [31:0] eaddr;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [31:0] sram_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5a5a_00ff;
   endfunction

   task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // One clock: drive, compare against the model, clock, advance model and SRAM.
   task automatic step(input bit rst, input bit br, input logic [31:0] tgt, input bit rdy,
                       output bit o_v, output logic [64:0] o_bus,
                       output bit o_en, output logic [31:0] o_addr);
      bit          e_v, e_en, pop, iss;
      int          occ;
      logic [31:0] req;
      reset       = rst;
      bus.br_bus  = {br, tgt};
      bus.id_ready = rdy;
      #3;
      e_v  = !rst && !br && (mbuf.size() > 0);
      pop  = e_v && rdy;
      occ  = mbuf.size() + int'(pend_v) - int'(pop);
      req  = br ? tgt : m_pc;
      iss  = !rst && (br || (!m_stall && occ < DEPTH));
      e_en = iss && (req[1:0] == 2'b00);
      o_v    = bus.if_valid;
      o_bus  = bus.if_to_id_bus;
      o_en   = bus.inst_sram_en;
      o_addr = bus.inst_sram_addr;
      chk("m_valid", 65'(o_v), 65'(e_v));
      if (e_v) chk("m_head", o_bus, mbuf[0]);
      if (rst) chk("m_rst_bus", o_bus, 65'h0);
      chk("m_en", 65'(o_en), 65'(e_en));
      if (e_en) chk("m_addr", 65'(o_addr), 65'(req));
      chk("m_we_wdata", 65'({bus.inst_sram_we, bus.inst_sram_wdata}), 65'h0);
      sram_q  = o_addr;
      sram_qv = o_en;
      @(posedge clk);
      if (rst) begin
         mbuf.delete();
         pend_v  = 1'b0;
         m_pc    = RST_PC;
         m_stall = 1'b0;
      end else begin
         if (br) mbuf.delete();
         else begin
            if (pop) void'(mbuf.pop_front());
            if (pend_v) mbuf.push_back({pend_adef, pend_pc, pend_adef ? 32'h0 : sram_word(pend_pc)});
         end
         pend_v = iss;
         if (iss) begin
            pend_pc   = req;
            pend_adef = (req[1:0] != 2'b00);
            m_stall   = pend_adef;
            m_pc      = pend_adef ? req : req + 32'd4;
         end
      end
      #1;
      bus.inst_sram_rdata = sram_qv ? sram_word(sram_q) : $urandom;
   endtask

   bit          v, e, found;
   logic [64:0] b;
   logic [31:0] a, tgt;

   initial begin
      reset = 1'b1;
      bus.br_bus = '0;
      bus.id_ready = 1'b0;
      bus.inst_sram_rdata = 32'h0;
      pend_v = 1'b0; pend_adef = 1'b0; pend_pc = 32'h0; m_pc = RST_PC; m_stall = 1'b0;

      // Reset release, steady stream, 10-cycle decode stall, release.
      tbl.push_back('{1, 1, 0, 32'h0,         0, 32'h0});
      tbl.push_back('{0, 1, 0, 32'h0,         1, RST_PC + 32'h00});
      tbl.push_back('{0, 1, 0, 32'h0,         1, RST_PC + 32'h04});
      tbl.push_back('{0, 1, 1, RST_PC + 32'h00, 1, RST_PC + 32'h08});
      tbl.push_back('{0, 1, 1, RST_PC + 32'h04, 1, RST_PC + 32'h0c});
      tbl.push_back('{0, 0, 1, RST_PC + 32'h08, 1, RST_PC + 32'h10});
      tbl.push_back('{0, 0, 1, RST_PC + 32'h08, 1, RST_PC + 32'h14});
      for (int i = 0; i < 8; i++) tbl.push_back('{0, 0, 1, RST_PC + 32'h08, 0, 32'h0});
      tbl.push_back('{0, 1, 1, RST_PC + 32'h08, 1, RST_PC + 32'h18});
      tbl.push_back('{0, 1, 1, RST_PC + 32'h0c, 1, RST_PC + 32'h1c});
      tbl.push_back('{0, 1, 1, RST_PC + 32'h10, 1, RST_PC + 32'h20});
      tbl.push_back('{0, 1, 1, RST_PC + 32'h14, 1, RST_PC + 32'h24});
      tbl.push_back('{0, 1, 1, RST_PC + 32'h18, 1, RST_PC + 32'h28});
      tbl.push_back('{0, 1, 1, RST_PC + 32'h1c, 1, RST_PC + 32'h2c});

      #1;
      foreach (tbl[i]) begin
         step(tbl[i].rst, 1'b0, 32'h0, tbl[i].rdy, v, b, e, a);
         chk("tbl_valid", 65'(v), 65'(tbl[i].ev));
         if (tbl[i].ev) chk("tbl_bus", b, {1'b0, tbl[i].epc, sram_word(tbl[i].epc)});
         chk("tbl_en", 65'(e), 65'(tbl[i].een));
         if (tbl[i].een) chk("tbl_addr", 65'(a), 65'(tbl[i].eaddr));
      end

      // Redirect with three entries buffered and one request outstanding.
      step(0, 1, 32'h1c00_0100, 1, v, b, e, a);
      chk("br_valid_low", 65'(v), 65'h0);
      chk("br_en", 65'(e), 65'h1);
      chk("br_addr", 65'(a), 65'h1c00_0100);
      step(0, 0, 32'h0, 1, v, b, e, a);
      chk("br_r1_valid", 65'(v), 65'h0);
      step(0, 0, 32'h0, 1, v, b, e, a);
      chk("br_r2_valid", 65'(v), 65'h1);
      chk("br_r2_bus", b, {1'b0, 32'h1c00_0100, sram_word(32'h1c00_0100)});
      for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, v, b, e, a);

      // Misaligned redirect: tagged entry, then no requests until the next redirect.
      step(0, 1, 32'h1c00_0102, 0, v, b, e, a);
      chk("adef_en", 65'(e), 65'h0);
      step(0, 0, 32'h0, 0, v, b, e, a);
      step(0, 0, 32'h0, 0, v, b, e, a);
      chk("adef_valid", 65'(v), 65'h1);
      chk("adef_bus", b, {1'b1, 32'h1c00_0102, 32'h0});
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 32'h0, 1, v, b, e, a);
         chk("adef_no_issue", 65'(e), 65'h0);
      end
      chk("adef_drained", 65'(v), 65'h0);
      step(0, 1, 32'h1c00_0200, 1, v, b, e, a);
      chk("resume_en", 65'(e), 65'h1);
      chk("resume_addr", 65'(a), 65'h1c00_0200);
      step(0, 0, 32'h0, 1, v, b, e, a);
      chk("resume_next", 65'(a), 65'h1c00_0204);
      step(0, 0, 32'h0, 1, v, b, e, a);
      chk("resume_bus", b, {1'b0, 32'h1c00_0200, sram_word(32'h1c00_0200)});

      // Address wrap.
      step(0, 1, 32'hffff_fffc, 1, v, b, e, a);
      chk("wrap_top", 65'(a), 65'hffff_fffc);
      step(0, 0, 32'h0, 1, v, b, e, a);
      chk("wrap_en", 65'(e), 65'h1);
      chk("wrap_zero", 65'(a), 65'h0);
      for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, v, b, e, a);

      // Reset with a full buffer and a request outstanding.
      for (int i = 0; i < 6; i++) step(0, 0, 32'h0, 0, v, b, e, a);
      step(0, 0, 32'h0, 1, v, b, e, a);
      step(1, 0, 32'h0, 1, v, b, e, a);
      step(0, 0, 32'h0, 1, v, b, e, a);
      chk("rst_valid_low", 65'(v), 65'h0);
      chk("rst_first_addr", 65'(a), 65'(RST_PC));
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         step(0, 0, 32'h0, 1, v, b, e, a);
         if (v) begin
            found = 1'b1;
            chk("rst_first_pc", 65'(b[PC_LSB +: 32]), 65'(RST_PC));
         end
      end
      if (!found) chk("rst_first_timeout", 65'h0, 65'h1);

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         bit r_rst, r_br, r_rdy;
         r_rst = ($urandom_range(0, 99) == 0);
         r_br  = ($urandom_range(0, 11) == 0);
         r_rdy = ($urandom_range(0, 2) != 0);
         tgt   = $urandom;
         if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
         if ($urandom_range(0, 15) == 0) tgt = 32'hffff_fff8;
         step(r_rst, r_br, tgt, r_rdy, v, b, e, a);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
